tq_transpose_pingpong_ctrl: RTL and testbench

//  Address/handshake controller for the ping-pong transpose memory between the 1st and 2nd 1-D transform stages.

---
 rtl/tq_pkg.sv | 19 +
 rtl/tq_transpose_pingpong_ctrl_if.sv | 36 +++
 rtl/tq_delay_line.sv | 32 +++
 rtl/tq_transpose_pingpong_ctrl.sv | 149 ++++++++++++++
 tb/tb_tq_transpose_pingpong_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tq_pkg.sv
// Shared definitions for the transpose ping-pong controller: TU size codes,
// bank index type and the beat-count helper.
package tq_pkg;

    typedef enum logic [1:0] {
        TQ_SZ4  = 2'b00,
        TQ_SZ8  = 2'b01,
        TQ_SZ16 = 2'b10,
        TQ_SZ32 = 2'b11
    } tq_size_e;

    typedef logic tq_bank_t;

    // Beats per block: 4x4 gives 1 << min_log2, each size step doubles it.
    function automatic int unsigned tq_beats(input logic [1:0] size, input int unsigned min_log2);
        return 32'd1 << (min_log2 + 32'(size));
    endfunction

endpackage

// File: rtl/tq_transpose_pingpong_ctrl_if.sv
// Bundle between stage 1, stage 2 and the transpose controller.
// Handshakes: a write beat transfers on a cycle where valid & ready are both high;
// a read is issued on a cycle where rd_ready is high and the read bank holds a full block.
interface tq_transpose_pingpong_ctrl_if #(parameter int ADDR_W = 5);

    logic              valid;
    logic [1:0]        transize;
    logic              ready;
    logic              wen;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_ready;
    logic              ren;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              rd_last;
    logic [1:0]        rd_size;
    logic              busy;
    logic [ADDR_W-1:0] dbg_wr_cnt;
    logic [ADDR_W-1:0] dbg_rd_cnt;
    logic [1:0]        dbg_full;

    modport master (
        output valid, transize, rd_ready,
        input  ready, wen, wr_bank, wr_addr, ren, rd_bank, rd_addr,
        input  rd_valid, rd_last, rd_size, busy, dbg_wr_cnt, dbg_rd_cnt, dbg_full
    );

    modport slave (
        input  valid, transize, rd_ready,
        output ready, wen, wr_bank, wr_addr, ren, rd_bank, rd_addr,
        output rd_valid, rd_last, rd_size, busy, dbg_wr_cnt, dbg_rd_cnt, dbg_full
    );

endinterface

// File: rtl/tq_delay_line.sv
// Async-reset shift register; q is the last stage, any_q is the OR of every stage
// so the parent can tell whether anything is still in flight.
module tq_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] any_q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        any_q = '0;
        for (int i = 0; i < DEPTH; i++) any_q = any_q | stage[i];
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/tq_transpose_pingpong_ctrl.sv
// Ping-pong transpose memory controller: stage-1 rows fill one bank while the
// other bank is read out column-wise for stage 2, with backpressure on both sides.
module tq_transpose_pingpong_ctrl
    import tq_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int MIN_LOG2 = 2,
    parameter int RD_LAT   = 2
) (
    input logic                        clk,
    input logic                        rst,
    tq_transpose_pingpong_ctrl_if.slave bus
);

    localparam int PIPE_W = 4;

    logic [ADDR_W-1:0] wr_cnt, wr_cnt_n;
    logic [ADDR_W-1:0] rd_cnt, rd_cnt_n;
    tq_bank_t          wr_bank, wr_bank_n;
    tq_bank_t          rd_bank, rd_bank_n;
    logic [1:0]        full, full_n;
    logic [1:0]        size_q [2];
    logic [1:0]        size_n [2];

    logic              ren_q, ren_n;
    logic              last_q, last_n;
    tq_bank_t          rd_bank_q, rd_bank_q_n;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_n;
    logic [1:0]        rsize_q, rsize_n;

    logic              ready;
    logic              wr_fire, wr_done;
    logic              rd_fire, rd_done;
    logic [1:0]        wr_size;
    logic [PIPE_W-1:0] pipe_q, pipe_any;

    function automatic logic [ADDR_W-1:0] last_idx(input logic [1:0] s);
        return ADDR_W'(tq_beats(s, MIN_LOG2) - 32'd1);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= '0;
            size_q[0] <= TQ_SZ4;
            size_q[1] <= TQ_SZ4;
            ren_q     <= 1'b0;
            last_q    <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_addr_q <= '0;
            rsize_q   <= TQ_SZ4;
        end else begin
            wr_cnt    <= wr_cnt_n;
            rd_cnt    <= rd_cnt_n;
            wr_bank   <= wr_bank_n;
            rd_bank   <= rd_bank_n;
            full      <= full_n;
            size_q[0] <= size_n[0];
            size_q[1] <= size_n[1];
            ren_q     <= ren_n;
            last_q    <= last_n;
            rd_bank_q <= rd_bank_q_n;
            rd_addr_q <= rd_addr_n;
            rsize_q   <= rsize_n;
        end
    end

    // Next state. The first beat of a block uses the live transize, later beats the latched one.
    always_comb begin
        ready   = !full[wr_bank];
        wr_fire = bus.valid & ready;
        wr_size = (wr_cnt == '0) ? bus.transize : size_q[wr_bank];
        wr_done = wr_fire && (wr_cnt == last_idx(wr_size));
        rd_fire = full[rd_bank] & bus.rd_ready;
        rd_done = rd_fire && (rd_cnt == last_idx(size_q[rd_bank]));

        wr_cnt_n    = wr_cnt;
        rd_cnt_n    = rd_cnt;
        wr_bank_n   = wr_bank;
        rd_bank_n   = rd_bank;
        full_n      = full;
        size_n[0]   = size_q[0];
        size_n[1]   = size_q[1];
        ren_n       = rd_fire;
        last_n      = rd_done;
        rd_bank_q_n = rd_bank_q;
        rd_addr_n   = rd_addr_q;
        rsize_n     = rsize_q;

        if (wr_fire) begin
            if (wr_cnt == '0) size_n[wr_bank] = bus.transize;
            if (wr_done) begin
                wr_cnt_n      = '0;
                full_n[wr_bank] = 1'b1;
                wr_bank_n     = ~wr_bank;
            end else begin
                wr_cnt_n = wr_cnt + 1'b1;
            end
        end

        // Completing a write and freeing a read bank can coincide; they always target different banks.
        if (rd_fire) begin
            rd_bank_q_n = rd_bank;
            rd_addr_n   = rd_cnt;
            rsize_n     = size_q[rd_bank];
            if (rd_done) begin
                rd_cnt_n        = '0;
                full_n[rd_bank] = 1'b0;
                rd_bank_n       = ~rd_bank;
            end else begin
                rd_cnt_n = rd_cnt + 1'b1;
            end
        end
    end

    tq_delay_line #(
        .W     (PIPE_W),
        .DEPTH (RD_LAT)
    ) u_rd_pipe (
        .clk   (clk),
        .rst   (rst),
        .d     ({ren_q, last_q, rsize_q}),
        .q     (pipe_q),
        .any_q (pipe_any)
    );

    // Outputs
    always_comb begin
        bus.ready      = ready;
        bus.wen        = wr_fire;
        bus.wr_bank    = wr_bank;
        bus.wr_addr    = wr_cnt;
        bus.ren        = ren_q;
        bus.rd_bank    = rd_bank_q;
        bus.rd_addr    = rd_addr_q;
        bus.rd_valid   = pipe_q[3];
        bus.rd_last    = pipe_q[2];
        bus.rd_size    = pipe_q[1:0];
        bus.busy       = bus.valid | (|full) | ren_q | pipe_any[3];
        bus.dbg_wr_cnt = wr_cnt;
        bus.dbg_rd_cnt = rd_cnt;
        bus.dbg_full   = full;
    end

endmodule

// File: tb/tb_tq_transpose_pingpong_ctrl.sv
// Self-checking bench for tq_transpose_pingpong_ctrl: drivers push expected read
// beats into scoreboard queues, a negedge monitor pops and compares them.
module tb_tq_transpose_pingpong_ctrl;

    localparam int ADDR_W   = 5;
    localparam int MIN_LOG2 = 2;
    localparam int RD_LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   valid_cnt = 0;
    int   last_wr_cyc = 0;
    logic model_wr_bank = 1'b0;

    logic [5:0] exp_rd_q[$];   // {bank, column address}
    logic [2:0] exp_out_q[$];  // {last, size}
    logic [5:0] e_rd;
    logic [2:0] e_out;

    tq_transpose_pingpong_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    tq_transpose_pingpong_ctrl #(
        .ADDR_W   (ADDR_W),
        .MIN_LOG2 (MIN_LOG2),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, got, exp);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            if (bus.ren) begin
                if (exp_rd_q.size() == 0) check("ren_unexpected", 32'd1, 32'd0);
                else begin
                    e_rd = exp_rd_q.pop_front();
                    check("rd_bank_addr", 32'({bus.rd_bank, bus.rd_addr}), 32'(e_rd));
                end
            end
            if (bus.rd_valid) begin
                valid_cnt++;
                if (exp_out_q.size() == 0) check("rd_valid_unexpected", 32'd1, 32'd0);
                else begin
                    e_out = exp_out_q.pop_front();
                    check("rd_last_size", 32'({bus.rd_last, bus.rd_size}), 32'(e_out));
                end
            end
        end
    end

    // Driver: called and returns at posedge+1. nb < beats gives a partial block.
    task automatic write_block(input logic [1:0] sz, input logic [1:0] mid_sz, input int nb,
                               output int stalls);
        int   beats;
        logic bank;
        beats  = 1 << (MIN_LOG2 + int'(sz));
        bank   = model_wr_bank;
        stalls = 0;
        for (int i = 0; i < beats; i++) begin
            exp_rd_q.push_back({bank, 5'(i)});
            exp_out_q.push_back({(i == beats - 1), sz});
        end
        for (int i = 0; i < nb; i++) begin
            bus.valid    = 1'b1;
            bus.transize = (i == 0) ? sz : mid_sz;
            @(negedge clk);
            while (!bus.ready && stalls < 200) begin
                stalls++;
                @(negedge clk);
            end
            if (!bus.ready) begin
                check("wr_ready_timeout", 32'd0, 32'd1);
                bus.valid = 1'b0;
                return;
            end
            check("wen", 32'(bus.wen), 32'd1);
            check("wr_addr", 32'(bus.wr_addr), 32'(i));
            check("wr_bank", 32'(bus.wr_bank), 32'(bank));
            last_wr_cyc = cyc;
            @(posedge clk); #1;
        end
        bus.valid = 1'b0;
        if (nb == beats) model_wr_bank = ~bank;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_out_q.size() != 0 || bus.busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_out_q.size() + exp_rd_q.size()), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int   st;
        int   n;
        int   n_ren;
        logic done;
        bus.valid    = 1'b0;
        bus.transize = 2'b00;
        bus.rd_ready = 1'b0;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_ren", 32'(bus.ren), 32'd0);
        check("rst_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_last", 32'(bus.rd_last), 32'd0);
        check("rst_size", 32'(bus.rd_size), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        bus.valid = 1'b1;
        #1;
        check("rst_busy_valid", 32'(bus.busy), 32'd1);
        bus.valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: single 4x4 block, latency
        bus.rd_ready = 1'b1;
        valid_cnt = 0;
        write_block(2'b00, 2'b00, 4, st);
        n = 0;
        @(negedge clk);
        while (!bus.ren && n < 20) begin @(negedge clk); n++; end
        check("s1_ren_latency", 32'(cyc - last_wr_cyc), 32'd2);
        while (!bus.rd_valid && n < 40) begin @(negedge clk); n++; end
        check("s1_valid_latency", 32'(cyc - last_wr_cyc), 32'(2 + RD_LAT));
        @(posedge clk); #1;
        wait_drain("s1_drain");
        check("s1_valid_cnt", 32'(valid_cnt), 32'd4);

        // 2: three back-to-back 32x32 blocks
        valid_cnt = 0;
        for (int b = 0; b < 3; b++) begin
            write_block(2'b11, 2'b11, 32, st);
            check("s2_no_stall", 32'(st), 32'd0);
        end
        wait_drain("s2_drain");
        check("s2_valid_cnt", 32'(valid_cnt), 32'd96);

        // 3: both banks full, release after the 8th issue
        bus.rd_ready = 1'b0;
        write_block(2'b01, 2'b01, 8, st);
        write_block(2'b01, 2'b01, 8, st);
        @(negedge clk);
        check("s3_ready_full", 32'(bus.ready), 32'd0);
        check("s3_full_flags", 32'(bus.dbg_full), 32'd3);
        @(posedge clk); #1;
        bus.rd_ready = 1'b1;
        n_ren = 0;
        n = 0;
        while (n_ren < 8 && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.ren) begin
                n_ren++;
                if (n_ren == 7) check("s3_ready_before", 32'(bus.ready), 32'd0);
                if (n_ren == 8) check("s3_ready_after", 32'(bus.ready), 32'd1);
            end
        end
        check("s3_issues", 32'(n_ren), 32'd8);
        @(posedge clk); #1;
        wait_drain("s3_drain");

        // 4: 16x16 read with rd_ready toggling
        bus.rd_ready = 1'b0;
        valid_cnt = 0;
        write_block(2'b10, 2'b10, 16, st);
        n = 0;
        while (exp_out_q.size() != 0 && n < 400) begin
            bus.rd_ready = (n % 2 == 0);
            @(posedge clk); #1;
            n++;
        end
        bus.rd_ready = 1'b1;
        wait_drain("s4_drain");
        check("s4_valid_cnt", 32'(valid_cnt), 32'd16);

        // 4b: random sizes under random read backpressure
        valid_cnt = 0;
        done = 1'b0;
        fork
            begin
                write_block(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0, st);
                exp_rd_q.delete();
                exp_out_q.delete();
                write_block(2'b10, 2'($urandom_range(0, 3)), 16, st);
                write_block(2'b00, 2'($urandom_range(0, 3)), 4, st);
                write_block(2'b01, 2'($urandom_range(0, 3)), 8, st);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.rd_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        bus.rd_ready = 1'b1;
        wait_drain("s4b_drain");
        check("s4b_valid_cnt", 32'(valid_cnt), 32'd28);

        // 5: mid-block size changes are ignored
        valid_cnt = 0;
        write_block(2'b11, 2'b01, 32, st);
        write_block(2'b01, 2'b11, 8, st);
        wait_drain("s5_drain");
        check("s5_valid_cnt", 32'(valid_cnt), 32'd40);

        // 6: reset with one bank full and a partial block in progress
        bus.rd_ready = 1'b0;
        write_block(2'b01, 2'b01, 8, st);
        write_block(2'b01, 2'b01, 5, st);
        check("s6_pre_full", 32'(bus.dbg_full != 2'b00), 32'd1);
        rst = 1'b0;
        #1;
        check("s6_full_cleared", 32'(bus.dbg_full), 32'd0);
        check("s6_ready", 32'(bus.ready), 32'd1);
        check("s6_wr_cnt", 32'(bus.dbg_wr_cnt), 32'd0);
        check("s6_ren", 32'(bus.ren), 32'd0);
        check("s6_valid", 32'(bus.rd_valid), 32'd0);
        exp_rd_q.delete();
        exp_out_q.delete();
        model_wr_bank = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.rd_ready = 1'b1;
        valid_cnt = 0;
        repeat (20) @(posedge clk);
        #1;
        check("s6_no_valid", 32'(valid_cnt), 32'd0);
        write_block(2'b00, 2'b00, 4, st);
        wait_drain("s6_drain");
        check("s6_valid_cnt", 32'(valid_cnt), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
